// File: rtl/clk_monitor.sv
// REFCLK qualifier: measures the reference period in FSBCLK cycles and drives CLKOK/ERR.
// Build option: define CLKMON_HYST_EN to tolerate one isolated out-of-range period while locked.
module clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int PER_MIN  = 2,
    parameter int PER_MAX  = 8,
    parameter int GOOD_CNT = 16
) (
    input  logic             FSBCLK,
    input  logic             RST,
    input  logic             REFCLK,
    input  logic             LOCKED,
    input  logic             ERR_CLR,
    output logic             CLKOK,
    output logic             ERR,
    output logic [CNT_W-1:0] LAST_PER
);

    localparam logic [CNT_W-1:0] PCNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] P_MIN    = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] P_MAX    = CNT_W'(PER_MAX);
    localparam logic [7:0]       G_TGT    = 8'(GOOD_CNT);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [2:0]       r_sync;      // [0]=s1, [1]=s2, [2]=s3 history
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_last_per;
    logic [7:0]       r_gcnt;
    logic             r_clkok;
    logic             r_err;
    logic             r_miss;
    state_t           r_state;

    logic             w_edge;
    logic             w_in_range;
    logic             w_timeout;
    logic [7:0]       w_gcnt_inc;
    state_t           w_state_next;
    logic [7:0]       w_gcnt_next;
    logic             w_err_set;
    logic             w_miss_next;
    logic             w_clkok_next;

    always_ff @(posedge FSBCLK or posedge RST) begin
        if (RST) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], REFCLK};
        end
    end

    assign w_edge     = r_sync[1] & ~r_sync[2];
    assign w_in_range = (r_pcnt >= P_MIN) && (r_pcnt <= P_MAX);
    assign w_timeout  = ~w_edge && (r_pcnt > P_MAX);
    assign w_gcnt_inc = r_gcnt + 8'd1;

    // Saturating so a dead REFCLK can never wrap back into the legal window.
    always_ff @(posedge FSBCLK or posedge RST) begin
        if (RST) begin
            r_pcnt <= '0;
        end else if (w_edge) begin
            r_pcnt <= CNT_W'(1);
        end else if (r_pcnt != PCNT_SAT) begin
            r_pcnt <= r_pcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge FSBCLK or posedge RST) begin
        if (RST) begin
            r_last_per <= '0;
        end else if (w_edge && (r_state != ST_HUNT)) begin
            r_last_per <= r_pcnt;
        end
    end

    always_ff @(posedge FSBCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_HUNT;
            r_gcnt  <= 8'd0;
            r_miss  <= 1'b0;
            r_clkok <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gcnt  <= w_gcnt_next;
            r_miss  <= w_miss_next;
            r_clkok <= w_clkok_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gcnt_next  = r_gcnt;
        w_err_set    = 1'b0;
        w_miss_next  = r_miss;
        if (!LOCKED) begin
            w_state_next = ST_HUNT;
            w_gcnt_next  = 8'd0;
            w_miss_next  = 1'b0;
            w_err_set    = (r_state == ST_LOCKED);
        end else begin
            case (r_state)
                ST_HUNT: begin
                    w_gcnt_next = 8'd0;
                    w_miss_next = 1'b0;
                    if (w_edge) begin
                        w_state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_timeout) begin
                        w_state_next = ST_HUNT;
                        w_gcnt_next  = 8'd0;
                    end else if (w_edge) begin
                        if (w_in_range) begin
                            w_gcnt_next = w_gcnt_inc;
                            if (w_gcnt_inc == G_TGT) begin
                                w_state_next = ST_LOCKED;
                            end
                        end else begin
                            w_gcnt_next = 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_timeout) begin
                        w_state_next = ST_HUNT;
                        w_gcnt_next  = 8'd0;
                        w_miss_next  = 1'b0;
                        w_err_set    = 1'b1;
                    end else if (w_edge) begin
                        if (w_in_range) begin
                            w_miss_next = 1'b0;
`ifdef CLKMON_HYST_EN
                        end else if (!r_miss) begin
                            w_miss_next = 1'b1;
`endif
                        end else begin
                            w_state_next = ST_MEASURE;
                            w_gcnt_next  = 8'd0;
                            w_miss_next  = 1'b0;
                            w_err_set    = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_HUNT;
                    w_gcnt_next  = 8'd0;
                    w_miss_next  = 1'b0;
                end
            endcase
        end
    end

    // CLKOK follows the next state so it drops on the very edge that judges a fault.
    always_comb begin
        w_clkok_next = (w_state_next == ST_LOCKED);
    end

    assign CLKOK    = r_clkok;
    assign ERR      = r_err;
    assign LAST_PER = r_last_per;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: REFCLK pulses of chosen period, outputs checked 1ns after FSBCLK rise.
// Expectations for the CLKMON_HYST_EN build are selected by the same macro.
module tb_clk_monitor;

    logic       FSBCLK  = 1'b0;
    logic       RST     = 1'b1;
    logic       REFCLK  = 1'b0;
    logic       LOCKED  = 1'b1;
    logic       ERR_CLR = 1'b0;
    logic       CLKOK;
    logic       ERR;
    logic [7:0] LAST_PER;

    int checks = 0;
    int errors = 0;

    clk_monitor #(
        .CNT_W   (8),
        .PER_MIN (2),
        .PER_MAX (8),
        .GOOD_CNT(16)
    ) dut (
        .FSBCLK  (FSBCLK),
        .RST     (RST),
        .REFCLK  (REFCLK),
        .LOCKED  (LOCKED),
        .ERR_CLR (ERR_CLR),
        .CLKOK   (CLKOK),
        .ERR     (ERR),
        .LAST_PER(LAST_PER)
    );

    always #5 FSBCLK = ~FSBCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge FSBCLK);
            #1;
        end
    endtask

    // One REFCLK rise followed by p-1 low cycles: consecutive edges are p FSBCLK cycles apart.
    task automatic ref_period(input int p);
        for (int i = 0; i < p; i++) begin
            REFCLK = (i == 0);
            @(posedge FSBCLK);
            #1;
        end
    endtask

    task automatic ref_run(input int n, input int p);
        repeat (n) ref_period(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        check("rst_clkok", 32'(CLKOK), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_last_per", 32'(LAST_PER), 0);
        RST = 1'b0;

        // Lock with period 5: arming edge, then 16 judged periods
        ref_period(5);
        check("arm_last_per", 32'(LAST_PER), 0);
        check("arm_clkok", 32'(CLKOK), 0);
        ref_run(15, 5);
        check("p5_15_clkok", 32'(CLKOK), 0);
        check("p5_last_per", 32'(LAST_PER), 5);
        ref_period(5);
        check("p5_16_clkok", 32'(CLKOK), 1);
        check("p5_16_err", 32'(ERR), 0);

        // Hold REFCLK low: pcnt is 3 now, reaches 9 after 6 cycles, judged on the 7th
        cyc(6);
        check("hold_pcnt9_clkok", 32'(CLKOK), 1);
        cyc(1);
        check("timeout_clkok", 32'(CLKOK), 0);
        check("timeout_err", 32'(ERR), 1);
        ERR_CLR = 1'b1;
        cyc(1);
        ERR_CLR = 1'b0;
        check("errclr_err", 32'(ERR), 0);

        // Relock from HUNT; arming edge must not load LAST_PER
        ref_period(5);
        check("rearm_last_per", 32'(LAST_PER), 5);
        ref_run(16, 5);
        check("relock_clkok", 32'(CLKOK), 1);

`ifndef CLKMON_HYST_EN
        ref_period(9);
        ref_period(5);
        check("p9_last_per", 32'(LAST_PER), 9);
        check("p9_clkok", 32'(CLKOK), 0);
        check("p9_err", 32'(ERR), 1);
`else
        ref_period(9);
        ref_period(5);
        check("hyst_miss_last_per", 32'(LAST_PER), 9);
        check("hyst_miss_clkok", 32'(CLKOK), 1);
        check("hyst_miss_err", 32'(ERR), 0);
        ref_period(9);
        check("hyst_good_last_per", 32'(LAST_PER), 5);
        check("hyst_good_clkok", 32'(CLKOK), 1);
        ref_period(9);
        check("hyst_miss2_clkok", 32'(CLKOK), 1);
        check("hyst_miss2_err", 32'(ERR), 0);
        ref_period(5);
        check("hyst_fault_last_per", 32'(LAST_PER), 9);
        check("hyst_fault_clkok", 32'(CLKOK), 0);
        check("hyst_fault_err", 32'(ERR), 1);
`endif
        ref_run(15, 5);
        check("refault_15_clkok", 32'(CLKOK), 0);
        ref_period(5);
        check("refault_16_clkok", 32'(CLKOK), 1);

        // LOCKED input drop while locked
        ERR_CLR = 1'b1;
        cyc(1);
        ERR_CLR = 1'b0;
        check("clr2_err", 32'(ERR), 0);
        LOCKED = 1'b0;
        cyc(1);
        LOCKED = 1'b1;
        check("unlock_clkok", 32'(CLKOK), 0);
        check("unlock_err", 32'(ERR), 1);
        ERR_CLR = 1'b1;
        cyc(1);
        ERR_CLR = 1'b0;
        check("clr3_err", 32'(ERR), 0);

        // MEASURE at gcnt=10, then an out-of-range period of 9
        ref_run(10, 5);
        ref_period(9);
        check("g10_last_per", 32'(LAST_PER), 5);
        ref_period(5);
        check("g10_bad_last_per", 32'(LAST_PER), 9);
        check("g10_bad_err", 32'(ERR), 0);
        check("g10_bad_clkok", 32'(CLKOK), 0);
        ref_run(15, 5);
        check("g0_15_clkok", 32'(CLKOK), 0);
        ref_period(5);
        check("g0_16_clkok", 32'(CLKOK), 1);

        // ERR_CLR coinciding with a LOCKED-state timeout
        check("pre_setwin_err", 32'(ERR), 0);
        cyc(6);
        check("pre_setwin_clkok", 32'(CLKOK), 1);
        ERR_CLR = 1'b1;
        cyc(1);
        ERR_CLR = 1'b0;
        check("setwin_err", 32'(ERR), 1);
        check("setwin_clkok", 32'(CLKOK), 0);

        // Boundary periods 8 and 2 both count as in range
        ref_period(8);
        ref_period(2);
        ref_period(5);
        check("p2_last_per", 32'(LAST_PER), 2);
        ref_run(13, 5);
        check("bnd_15_clkok", 32'(CLKOK), 0);
        ref_period(5);
        check("bnd_16_clkok", 32'(CLKOK), 1);

        // Timeout to HUNT, re-enter MEASURE, then asynchronous reset mid-cycle
        cyc(7);
        check("to2_clkok", 32'(CLKOK), 0);
        ref_run(4, 5);
        check("meas_last_per", 32'(LAST_PER), 5);
        check("meas_err", 32'(ERR), 1);
        RST = 1'b1;
        #2;
        check("async_rst_clkok", 32'(CLKOK), 0);
        check("async_rst_err", 32'(ERR), 0);
        check("async_rst_last_per", 32'(LAST_PER), 0);
        @(posedge FSBCLK);
        #1;
        RST = 1'b0;
        ref_period(5);
        check("post_rst_arm_last_per", 32'(LAST_PER), 0);
        ref_period(5);
        check("post_rst_last_per", 32'(LAST_PER), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
